xmas_scene_sequencer: RTL



---
 rtl/xmas_pkg.sv | 23 ++
 rtl/xmas_scene_sequencer_sync_edge.sv | 25 ++
 rtl/xmas_scene_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/xmas_pkg.sv
// Shared scene and star-phase definitions for the Christmas-tree scene sequencer and renderer.
package xmas_pkg;

  typedef enum logic [2:0] {
    SC_TREE  = 3'd0,
    SC_LINE1 = 3'd1,
    SC_LINE2 = 3'd2,
    SC_HOLD  = 3'd3,
    SC_CLEAR = 3'd4
  } scene_e;

  // Star colour the renderer draws for each star_phase value
  typedef enum logic [1:0] {
    STAR_GOLD  = 2'd0,
    STAR_RED   = 2'd1,
    STAR_WHITE = 2'd2,
    STAR_BLUE  = 2'd3
  } star_phase_e;

  localparam int unsigned TEXT1_LEN_DEF = 10;
  localparam int unsigned TEXT2_LEN_DEF = 18;

endpackage

// File: rtl/xmas_scene_sequencer_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with a one-cycle rising-edge output.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], async_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign level_o = sh_q[1];
  assign rise_o  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/xmas_scene_sequencer.sv
// Frame-synchronous scene sequencer: tree, line-1 reveal, line-2 reveal, hold, clear, repeat.
module xmas_scene_sequencer
  import xmas_pkg::*;
#(
  parameter int unsigned TREE_FRAMES = 60,
  parameter int unsigned CHAR_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES = 180,
  parameter int unsigned STAR_FRAMES = 64,
  parameter int unsigned TEXT1_LEN   = TEXT1_LEN_DEF,
  parameter int unsigned TEXT2_LEN   = TEXT2_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause_i,
  input  logic       skip_i,
  output logic [2:0] scene,
  output logic [3:0] text1_count,
  output logic [4:0] text2_count,
  output logic [1:0] star_phase,
  output logic       lights_on,
  output logic       frame_strobe
);

  localparam logic [7:0] TREE_LIM = 8'(TREE_FRAMES - 1);
  localparam logic [7:0] CHAR_LIM = 8'(CHAR_FRAMES - 1);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] STAR_LIM = 8'(STAR_FRAMES - 1);
  localparam logic [3:0] T1_FULL  = 4'(TEXT1_LEN);
  localparam logic [4:0] T2_FULL  = 5'(TEXT2_LEN);

  logic pause_s, pause_rise_unused;
  logic skip_rise, skip_level_unused;

  sync_edge u_pause_sync (.clk(clk), .rst_n(rst_n), .async_i(pause_i),
                          .level_o(pause_s), .rise_o(pause_rise_unused));
  sync_edge u_skip_sync  (.clk(clk), .rst_n(rst_n), .async_i(skip_i),
                          .level_o(skip_level_unused), .rise_o(skip_rise));

  scene_e     scene_q, scene_d;
  logic [3:0] t1_q, t1_d;
  logic [4:0] t2_q, t2_d;
  logic [1:0] phase_q, phase_d;
  logic       lights_q, lights_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] star_q, star_d;
  logic       vs_q, strobe_q, skip_pend_q, skip_pend_d;
  logic       frame_tick, advance, expire;
  logic [7:0] lim;

  assign frame_tick = vsync & ~vs_q;
  assign advance    = frame_tick & ~pause_s;

  always_comb begin
    scene_d     = scene_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    phase_d     = phase_q;
    lights_d    = lights_q;
    dwell_d     = dwell_q;
    star_d      = star_q;
    skip_pend_d = skip_pend_q | skip_rise;
    case (scene_q)
      SC_TREE:           lim = TREE_LIM;
      SC_LINE1, SC_LINE2: lim = CHAR_LIM;
      SC_HOLD:           lim = HOLD_LIM;
      default:           lim = '0;
    endcase
    expire = (dwell_q == lim);

    if (advance) begin
      if (star_q == STAR_LIM) begin
        star_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        star_d = star_q + 8'd1;
      end
      dwell_d = expire ? '0 : dwell_q + 8'd1;

      if (skip_pend_q) begin
        // A skip edge arriving on the consuming cycle stays pending for the next frame
        skip_pend_d = skip_rise;
        dwell_d     = '0;
        case (scene_q)
          SC_TREE:  begin scene_d = SC_LINE1; t1_d = '0; t2_d = '0; lights_d = 1'b1; end
          SC_LINE1: begin scene_d = SC_LINE2; t1_d = T1_FULL; end
          SC_LINE2: begin scene_d = SC_HOLD;  t1_d = T1_FULL; t2_d = T2_FULL; end
          SC_HOLD:  scene_d = SC_CLEAR;
          SC_CLEAR: begin scene_d = SC_TREE; t1_d = '0; t2_d = '0; lights_d = 1'b0; end
          default:  scene_d = SC_CLEAR;
        endcase
      end else begin
        case (scene_q)
          SC_TREE: begin
            lights_d = 1'b1;
            t1_d     = '0;
            t2_d     = '0;
            if (expire) scene_d = SC_LINE1;
          end
          SC_LINE1: if (expire) begin
            if (t1_q >= T1_FULL - 4'd1) begin
              t1_d    = T1_FULL;
              scene_d = SC_LINE2;
            end else begin
              t1_d = t1_q + 4'd1;
            end
          end
          SC_LINE2: begin
            t1_d = T1_FULL;
            if (expire) begin
              if (t2_q >= T2_FULL - 5'd1) begin
                t2_d    = T2_FULL;
                scene_d = SC_HOLD;
              end else begin
                t2_d = t2_q + 5'd1;
              end
            end
          end
          SC_HOLD: begin
            lights_d = ~dwell_d[4];
            if (expire) scene_d = SC_CLEAR;
          end
          SC_CLEAR: begin
            scene_d  = SC_TREE;
            t1_d     = '0;
            t2_d     = '0;
            lights_d = 1'b0;
          end
          default: scene_d = SC_CLEAR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_q     <= SC_TREE;
      t1_q        <= '0;
      t2_q        <= '0;
      phase_q     <= '0;
      lights_q    <= 1'b0;
      dwell_q     <= '0;
      star_q      <= '0;
      vs_q        <= 1'b0;
      strobe_q    <= 1'b0;
      skip_pend_q <= 1'b0;
    end else begin
      scene_q     <= scene_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      phase_q     <= phase_d;
      lights_q    <= lights_d;
      dwell_q     <= dwell_d;
      star_q      <= star_d;
      vs_q        <= vsync;
      strobe_q    <= frame_tick;
      skip_pend_q <= skip_pend_d;
    end
  end

  assign scene        = scene_q;
  assign text1_count  = t1_q;
  assign text2_count  = t2_q;
  assign star_phase   = phase_q;
  assign lights_on    = lights_q;
  assign frame_strobe = strobe_q;

endmodule
